tff_updown_counter: RTL

// - Parametrised synchronous up/down counter built from a chain of T flip-flop cells.
// - Successor to the single-bit T flip-flop primitive: adds width, direction, parallel load,

---
 rtl/tff_cnt_pkg.sv | 24 ++
 rtl/tff_cell.sv | 38 +++
 rtl/tff_updown_counter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tff_cnt_pkg.sv
// tff_cnt_pkg: shared encodings and helpers for the T-flip-flop up/down counter.
//   MODE_WRAP / MODE_SAT : values of the 'sat' mode select input
//   DIR_DN / DIR_UP      : values of the 'up' direction input
//   all_ones(width)      : all-ones constant of the given width (counter MAX)
package tff_cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DN = 1'b0;
  localparam logic DIR_UP = 1'b1;

  // Returns a value whose low 'width' bits are set; callers truncate to their width.
  function automatic logic [63:0] all_ones(input int unsigned width);
    logic [63:0] res;
    if (width >= 64) begin
      res = '1;
    end else begin
      res = (64'd1 << width) - 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// tff_cell: one bit of the counter, a T flip-flop with synchronous clear and load.
// Priority on each rising edge: clr > ld > t.
//   clk : clock
//   clr : synchronous active-high clear
//   t   : toggle enable
//   ld  : parallel load strobe
//   d   : parallel load data
//   q   : registered bit value
module tff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (ld) begin
      q_d = d;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: WIDTH-bit synchronous up/down counter built from a chain of
// T flip-flop cells, with parallel load, wrap/saturate mode, a registered
// terminal-count pulse and a sticky overflow/underflow flag.
//   clk      : clock, all state changes on the rising edge
//   clr      : synchronous active-high clear, highest priority
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : parallel load strobe (beats en)
//   load_val : value loaded when load = 1
//   sat      : mode select, 1 = saturate at the boundary, 0 = wrap
//   ovf_clr  : clears the sticky ovf flag (a boundary hit in the same cycle wins)
//   q        : counter value
//   tc       : one-cycle pulse for every boundary hit
//   ovf      : sticky boundary-hit flag
module tff_updown_counter
  import tff_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter logic        SAT_DEF = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] q_cells;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;

  logic boundary;
  logic freeze;
  logic hit;

  logic tc_q, tc_d;
  logic ovf_q, ovf_d;
  logic mode_q;

  // Ripple-AND toggle chains: bit i toggles once every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_chain    = '0;
    dn_chain    = '0;
    up_chain[0] = 1'b1;
    dn_chain[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      up_chain[i] = up_chain[i-1] & q_cells[i-1];
      dn_chain[i] = dn_chain[i-1] & ~q_cells[i-1];
    end
  end

  // Boundary for the direction sampled this cycle: MAX going up, zero going down.
  always_comb begin
    boundary = 1'b0;
    if (up == DIR_UP) begin
      boundary = (q_cells == MAX);
    end else begin
      boundary = (q_cells == '0);
    end
  end

  // In saturate mode a boundary attempt freezes every cell instead of wrapping.
  assign freeze = ~en | ((sat == MODE_SAT) & boundary);

  always_comb begin
    t = '0;
    if (!freeze) begin
      t = (up == DIR_UP) ? up_chain : dn_chain;
    end
  end

  // A boundary hit only counts when the count path actually owns this edge.
  assign hit = ~clr & ~load & en & boundary;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_cells
    tff_cell u_cell (
      .clk (clk),
      .clr (clr),
      .t   (t[i]),
      .ld  (load),
      .d   (load_val[i]),
      .q   (q_cells[i])
    );
  end

  always_comb begin
    tc_d  = hit;
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (hit) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      mode_q <= SAT_DEF;
    end else begin
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      mode_q <= sat;
    end
  end

  // Last sampled mode; sat acts on the edge it is sampled, so this latch only
  // tracks it and has no effect on the count path.
  logic unused_mode_q;
  assign unused_mode_q = mode_q;

  assign q   = q_cells;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
